// File: rtl/name_seq_tx.sv
// Magic-sequence ASCII transmitter: sends CH0..CH(LEN-1) once per start request over a valid/ready handshake.
// Define NAME_SEQ_APPEND_ENTER_EN to append a 7'h0A terminator after the last character.
module name_seq_tx #(
    parameter int unsigned LEN = 5,
    parameter logic [6:0]  CH0 = 7'h48,
    parameter logic [6:0]  CH1 = 7'h6F,
    parameter logic [6:0]  CH2 = 7'h73,
    parameter logic [6:0]  CH3 = 7'h73,
    parameter logic [6:0]  CH4 = 7'h65
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ready,
    output logic [6:0] ascii,
    output logic       valid,
    output logic       busy,
    output logic       done
);

    generate
        if (LEN < 1 || LEN > 5) begin : g_bad_len
            $error("name_seq_tx: LEN must be in 1..5");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t     state_q;
    logic [2:0] idx_q;
    logic [6:0] ascii_q;
    logic       valid_q;
    logic       busy_q;
    logic       done_q;

    logic last_char;
    logic seq_end;
    logic insert_term;

    function automatic logic [6:0] char_at(input logic [2:0] i);
        case (i)
            3'd0:    char_at = CH0;
            3'd1:    char_at = CH1;
            3'd2:    char_at = CH2;
            3'd3:    char_at = CH3;
            3'd4:    char_at = CH4;
            default: char_at = 7'h00;
        endcase
    endfunction

    assign last_char = (idx_q == 3'(LEN - 1));

`ifdef NAME_SEQ_APPEND_ENTER_EN
    logic term_q;

    // The terminator reuses the final index slot, so idx never passes LEN-1.
    assign seq_end     = term_q;
    assign insert_term = last_char & ~term_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            term_q <= 1'b0;
        end else if (state_q == IDLE) begin
            term_q <= 1'b0;
        end else if (state_q == SEND && valid_q && ready && insert_term) begin
            term_q <= 1'b1;
        end
    end
`else
    assign seq_end     = last_char;
    assign insert_term = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            ascii_q <= 7'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: done defaults low every cycle so it can only ever be a one-cycle pulse.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    idx_q <= 3'd0;
                    if (start) begin
                        state_q <= SEND;
                        ascii_q <= CH0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        ascii_q <= 7'h00;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                SEND: begin
                    if (valid_q && ready) begin
                        if (seq_end) begin
                            state_q <= DONE;
                            ascii_q <= 7'h00;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (insert_term) begin
                            ascii_q <= 7'h0A;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            ascii_q <= char_at(idx_q + 3'd1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ascii = ascii_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: doc/name_seq_tx.md
Name: name_seq_tx

Overview:
- Transmit side of the magic-sequence ASCII link: emits a stored 7-bit ASCII string one character per accepted clock cycle.
- Used to drive the sequence recognizer, which samples one ASCII bitmap per rising clk, and to replace keyboard-fed stimulus in benches.
- Each start request sends one full sequence.
- Flow control is a valid/ready handshake, so a stalling consumer is also supported.

Parameters:
- LEN, 5, number of characters sent per sequence; legal range 1..5; uses CH0..CH(LEN-1).
- CH0, 7'h48, 1st character ('H').
- CH1, 7'h6F, 2nd character ('o').
- CH2, 7'h73, 3rd character ('s').
- CH3, 7'h73, 4th character ('s').
- CH4, 7'h65, 5th character ('e').

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request one sequence; sampled only in IDLE.
- ready  input  1  consumer accepts the current character this cycle; tie to 1 for the recognizer.
- ascii  output  7  current character bitmap, [6] = MSB.
- valid  output  1  ascii holds a character to be transferred.
- busy  output  1  sequence in progress (SEND state).
- done  output  1  one-cycle pulse after the final character is transferred.

Behaviour:
- All outputs are registered.
- Reset: while rst=1, state=IDLE, idx=0, ascii=7'h00, valid=0, busy=0, done=0. Reset asserted mid-sequence aborts it immediately, with no further characters and no done pulse.
- States: IDLE, SEND, DONE.
- IDLE, start=1 -> SEND. On the next cycle: valid=1, busy=1, ascii=CH0, idx=0. Latency from start to first valid character is one clk.
- IDLE, start=0: stay in IDLE; valid=0 and ascii=7'h00.
- SEND, transfer condition: valid=1 and ready=1 at a rising edge.
  - If idx<LEN-1: idx+1, ascii=CH[idx+1], valid stays 1.
  - If idx=LEN-1: go to DONE; valid=0, busy=0, ascii=7'h00, done=1.
- SEND, ready=0: hold ascii, valid, and idx unchanged; no timeout.
- DONE: lasts exactly one cycle with done=1, then goes to IDLE with done=0.
- start while in SEND or DONE is ignored. No queuing.
- start held high continuously: a new sequence begins on the cycle after DONE, which leaves a gap of exactly 2 cycles (DONE, IDLE) with valid=0.
- With ready=1, characters appear on LEN consecutive cycles. The recognizer fed from ascii asserts match after the last character's clock edge.
- idx is 3 bits and never exceeds LEN-1. No wrap-around within a sequence.
- LEN outside 1..5 is a configuration error: elaboration fails through a generate-time check.

Optional Feature:
- Macro: NAME_SEQ_APPEND_ENTER_EN.
- Defined: after CH(LEN-1) is transferred, one extra character 7'h0A (ENTER/newline) is sent under the same ready handshake. done pulses only after 7'h0A is transferred. Total characters sent = LEN+1.
- Undefined: no terminator is sent; done follows the last CH transfer; total characters sent = LEN.

Test Plan:
- rst=1 mid-sequence (after 2 characters) -> ascii=00, valid=0, busy=0, done=0 immediately, without waiting for clk. After release: IDLE, and a new start sends from CH0.
- Defaults, ready=1, start pulse at cycle 0 -> ascii=48,6F,73,73,65 with valid=1 on cycles 1-5. done=1 on cycle 6 only. busy=1 on cycles 1-5.
- ready=0 for 3 cycles while ascii=6F -> ascii stays 6F and valid stays 1. After ready returns, 73 follows. Total 5 transfers, no duplicates or drops.
- start re-asserted on cycles 2-4 during SEND -> ignored. Exactly one done pulse. start held high: second sequence's CH0 appears 2 cycles after the first done.
- Connected to the recognizer with ready=1 -> match=1 immediately after the 5th transfer edge. With CH2 overridden to 7'h61 -> match stays 0.
- NAME_SEQ_APPEND_ENTER_EN defined, LEN=5 -> 6th transfer is 0A, then done. With LEN=1 -> sends 48, then 0A, then done.
